// File: rtl/tone_sequencer.sv
// tone_sequencer: plays a short melody on the tone clock generator.
// It holds a writable table of {half-period, duration} entries. On start it plays the first len
// entries. Every note boundary reloads maxval and pulses the generator reset for one cycle.
// A period of 0 is a rest. Playback can run once or loop, and stop aborts it.
//
// Ports:
//   clk_i, reset               clock, synchronous active-high reset
//   wr_en/wr_addr/wr_period/wr_dur   table write port (any state)
//   len, loop                  playback length and loop mode, sampled on accepted start
//   start, stop, tick          control strobes and duration time base
//   maxval_o, gen_reset_o      clkgen programming
//   tone_en_o, busy_o, done_o, note_idx_o   status
module tone_sequencer #(
  parameter int unsigned N  = 16,
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 4
) (
  input  logic          clk_i,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [N-1:0]  wr_period,
  input  logic [DW-1:0] wr_dur,
  input  logic [AW:0]   len,
  input  logic          loop,
  input  logic          start,
  input  logic          stop,
  input  logic          tick,
  output logic [N-1:0]  maxval_o,
  output logic          gen_reset_o,
  output logic          tone_en_o,
  output logic          busy_o,
  output logic          done_o,
  output logic [AW-1:0] note_idx_o
);

  localparam int unsigned Depth = 2 ** AW;
  localparam logic [AW:0] LenMax = (AW + 1)'(Depth);

  typedef enum logic [1:0] {StIdle, StLoad, StPlay} state_e;

  state_e        state_q;
  logic [N-1:0]  period_mem_q [Depth];
  logic [DW-1:0] dur_mem_q    [Depth];
  logic [AW:0]   len_q;
  logic          loop_q;
  logic [AW-1:0] idx_q;
  logic [DW-1:0] dur_q;
  logic [DW-1:0] cnt_q;
  logic [N-1:0]  maxval_q;
  logic          gen_reset_q;
  logic          tone_en_q;
  logic          busy_q;
  logic          done_q;

  logic [AW:0] len_clamped;
  logic        note_end;
  logic        last_note;

  assign len_clamped = (len > LenMax) ? LenMax : len;
  // dur=0 ends the note immediately; otherwise end on the cycle the dur-th tick arrives.
  assign note_end    = (dur_q == '0) || (tick && ((cnt_q + DW'(1)) == dur_q));
  assign last_note   = (({1'b0, idx_q} + (AW + 1)'(1)) == len_q);

  // Note table; a LOAD in the same cycle as a write to that entry reads the old contents.
  always_ff @(posedge clk_i) begin
    if (reset) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        period_mem_q[i] <= '0;
        dur_mem_q[i]    <= '0;
      end
    end else if (wr_en) begin
      period_mem_q[wr_addr] <= wr_period;
      dur_mem_q[wr_addr]    <= wr_dur;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset) begin
      state_q     <= StIdle;
      len_q       <= '0;
      loop_q      <= 1'b0;
      idx_q       <= '0;
      dur_q       <= '0;
      cnt_q       <= '0;
      maxval_q    <= '0;
      gen_reset_q <= 1'b1;
      tone_en_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start && !stop) begin
            len_q  <= len_clamped;
            loop_q <= loop;
            idx_q  <= '0;
            if (len_clamped == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q <= StLoad;
              busy_q  <= 1'b1;
            end
          end
        end
        StLoad: begin
          if (stop) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else begin
            state_q     <= StPlay;
            maxval_q    <= period_mem_q[idx_q];
            dur_q       <= dur_mem_q[idx_q];
            tone_en_q   <= (period_mem_q[idx_q] != '0);
            cnt_q       <= '0;
            gen_reset_q <= 1'b0;
          end
        end
        StPlay: begin
          if (stop) begin
            state_q     <= StIdle;
            busy_q      <= 1'b0;
            gen_reset_q <= 1'b1;
            tone_en_q   <= 1'b0;
          end else begin
            if (tick) begin
              cnt_q <= cnt_q + DW'(1);
            end
            if (note_end) begin
              gen_reset_q <= 1'b1;
              tone_en_q   <= 1'b0;
              if (!last_note) begin
                idx_q   <= idx_q + AW'(1);
                state_q <= StLoad;
              end else if (loop_q) begin
                idx_q   <= '0;
                state_q <= StLoad;
              end else begin
                state_q <= StIdle;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign maxval_o    = maxval_q;
  assign gen_reset_o = gen_reset_q;
  assign tone_en_o   = tone_en_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign note_idx_o  = idx_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Scoreboard bench for tone_sequencer: stimulus pushes the expected notes and done pulses.
// A monitor rebuilds each played note from the outputs and compares it against the queue.
module tb_tone_sequencer;

  localparam int unsigned N  = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned AW = 4;

  logic          clk_i = 1'b0;
  logic          reset = 1'b1;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [N-1:0]  wr_period = '0;
  logic [DW-1:0] wr_dur = '0;
  logic [AW:0]   len = '0;
  logic          loop = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          tick = 1'b1;
  logic [N-1:0]  maxval_o;
  logic          gen_reset_o;
  logic          tone_en_o;
  logic          busy_o;
  logic          done_o;
  logic [AW-1:0] note_idx_o;

  tone_sequencer #(.N(N), .DW(DW), .AW(AW)) dut (
    .clk_i      (clk_i),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_period  (wr_period),
    .wr_dur     (wr_dur),
    .len        (len),
    .loop       (loop),
    .start      (start),
    .stop       (stop),
    .tick       (tick),
    .maxval_o   (maxval_o),
    .gen_reset_o(gen_reset_o),
    .tone_en_o  (tone_en_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .note_idx_o (note_idx_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit is_done;
    int idx;
    int maxv;
    int ten;
    int plen;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic void exp_note(input int i, input int m, input int t, input int l);
    exp_t e;
    e.is_done = 1'b0; e.idx = i; e.maxv = m; e.ten = t; e.plen = l;
    exp_q.push_back(e);
  endfunction

  function automatic void exp_done();
    exp_t e;
    e.is_done = 1'b1; e.idx = 0; e.maxv = 0; e.ten = 0; e.plen = 0;
    exp_q.push_back(e);
  endfunction

  // Monitor: a note is the run of PLAY cycles (busy, generator released).
  bit in_note = 1'b0;
  int cur_idx, cur_max, cur_ten, cur_len;

  always @(negedge clk_i) begin
    exp_t e;
    if (reset) begin
      in_note = 1'b0;
    end else begin
      if (busy_o && !gen_reset_o) begin
        if (!in_note) begin
          in_note = 1'b1;
          cur_idx = int'(note_idx_o);
          cur_max = int'(maxval_o);
          cur_ten = int'(tone_en_o);
          cur_len = 0;
        end
        cur_len++;
      end else if (in_note) begin
        in_note = 1'b0;
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_note actual=idx%0d required=none", cur_idx);
        end else begin
          e = exp_q.pop_front();
          chk("note_is_note", 0, int'(e.is_done));
          chk("note_idx", cur_idx, e.idx);
          chk("note_maxval", cur_max, e.maxv);
          chk("note_tone_en", cur_ten, e.ten);
          chk("note_play_cycles", cur_len, e.plen);
        end
      end
      if (done_o) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_done actual=1 required=0");
        end else begin
          e = exp_q.pop_front();
          chk("done_expected", 1, int'(e.is_done));
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wr(input int a, input int p, input int d);
    wr_en = 1'b1; wr_addr = AW'(a); wr_period = N'(p); wr_dur = DW'(d);
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic go(input int l, input bit lp);
    len = (AW + 1)'(l); loop = lp; start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 300; i++) begin
      if (!busy_o) break;
      cyc();
    end
    if (busy_o) begin
      tests++; fails++;
      $display("FAIL %s_timeout actual=busy required=idle", name);
    end
    cyc();
    cyc();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    cyc(); cyc();
    chk("rst_gen_reset", int'(gen_reset_o), 1);
    chk("rst_maxval", int'(maxval_o), 0);
    chk("rst_tone_en", int'(tone_en_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_idx", int'(note_idx_o), 0);
    reset = 1'b0;
    cyc();

    // One-shot
    wr(0, 100, 3); wr(1, 200, 2);
    exp_note(0, 100, 1, 3); exp_note(1, 200, 1, 2); exp_done();
    go(2, 1'b0);
    chk("os_load_busy", int'(busy_o), 1);
    chk("os_load_gen_reset", int'(gen_reset_o), 1);
    chk("os_load_idx", int'(note_idx_o), 0);
    cyc();
    chk("os_play_maxval", int'(maxval_o), 100);
    chk("os_play_tone_en", int'(tone_en_o), 1);
    chk("os_play_gen_reset", int'(gen_reset_o), 0);
    wait_idle("oneshot");
    chk("os_after_gen_reset", int'(gen_reset_o), 1);

    // Rest and zero duration
    wr(0, 0, 2); wr(1, 50, 0); wr(2, 60, 1);
    exp_note(0, 0, 0, 2); exp_note(1, 50, 1, 1); exp_note(2, 60, 1, 1); exp_done();
    go(3, 1'b0);
    wait_idle("rest");

    // Loop then stop during the first cycle of the second pass over entry 1
    wr(0, 100, 3); wr(1, 200, 2);
    exp_note(0, 100, 1, 3); exp_note(1, 200, 1, 2);
    exp_note(0, 100, 1, 3); exp_note(1, 200, 1, 1);
    go(2, 1'b1);
    for (int i = 0; i < 12; i++) cyc();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    chk("stop_busy", int'(busy_o), 0);
    chk("stop_gen_reset", int'(gen_reset_o), 1);
    chk("stop_tone_en", int'(tone_en_o), 0);
    cyc(); cyc(); cyc();

    // Live write of the playing entry
    exp_note(0, 100, 1, 3); exp_note(1, 200, 1, 2); exp_note(0, 300, 1, 1);
    go(2, 1'b1);
    cyc();
    wr(0, 300, 3);
    for (int i = 0; i < 6; i++) cyc();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    cyc(); cyc();

    // len = 0
    exp_done();
    go(0, 1'b0);
    chk("len0_busy", int'(busy_o), 0);
    chk("len0_done", int'(done_o), 1);
    cyc();
    chk("len0_done_one_cycle", int'(done_o), 0);
    cyc();

    // len = 20 clamps to 16
    for (int i = 0; i < 16; i++) wr(i, (i + 1) * 10, 1);
    for (int i = 0; i < 16; i++) exp_note(i, (i + 1) * 10, 1, 1);
    exp_done();
    go(20, 1'b0);
    wait_idle("len20");

    // start and stop together
    stop = 1'b1;
    go(2, 1'b0);
    stop = 1'b0;
    chk("startstop_busy", int'(busy_o), 0);
    chk("startstop_gen_reset", int'(gen_reset_o), 1);
    cyc(); cyc();
    chk("startstop_busy_later", int'(busy_o), 0);

    // Reset mid-playback clears state and table
    wr(0, 100, 3);
    go(1, 1'b0);
    cyc(); cyc();
    reset = 1'b1;
    cyc();
    chk("midrst_gen_reset", int'(gen_reset_o), 1);
    chk("midrst_busy", int'(busy_o), 0);
    chk("midrst_maxval", int'(maxval_o), 0);
    chk("midrst_tone_en", int'(tone_en_o), 0);
    cyc();
    reset = 1'b0;
    cyc();
    exp_note(0, 0, 0, 1); exp_done();
    go(1, 1'b0);
    wait_idle("midrst");

    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tone_sequencer.md
# tone_sequencer

Melody sequencer driving the programmable tone clock generator (`maxval`/`reset` inputs of the tone clkgen). Holds a small writable table of notes, each a half-period count plus a duration in time-base ticks, and steps through the first `len` entries on `start`, reprogramming and restarting the generator at every note boundary. Supports rests, one-shot or looped playback, and abort. Sits between the control/register logic and the tone clkgen.

## Interface
- `N`, 16, width of half-period value (matches clkgen `maxval` width)
- `DW`, 16, width of note duration in ticks
- `AW`, 4, table address width; `DEPTH = 2**AW` entries

- `clk_i`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `wr_en`  in  1  table write strobe
- `wr_addr`  in  AW  table write address
- `wr_period`  in  N  half-period count for entry; 0 = rest
- `wr_dur`  in  DW  duration in ticks for entry
- `len`  in  AW+1  number of entries to play, sampled on accepted `start`
- `loop`  in  1  1 = restart at entry 0 after last note; sampled on accepted `start`
- `start`  in  1  begin playback (single-cycle pulse or level)
- `stop`  in  1  abort playback
- `tick`  in  1  duration time-base strobe, one cycle wide
- `maxval_o`  out  N  half-period value to clkgen `maxval`
- `gen_reset_o`  out  1  reset to clkgen
- `tone_en_o`  out  1  1 while a non-rest note sounds
- `busy_o`  out  1  1 in LOAD or PLAY
- `done_o`  out  1  one-cycle pulse at end of one-shot playback
- `note_idx_o`  out  AW  index of current entry

## Operation
- Table: DEPTH registers of {period, dur}; written when `wr_en`=1, any state. Entry contents latched into working registers in LOAD; writes to the playing entry take effect on its next LOAD. Write and LOAD to same address in the same cycle: LOAD gets the old value.
- States: IDLE, LOAD, PLAY.
- IDLE: `start`=1 and `stop`=0 → capture `len` (values > DEPTH clamp to DEPTH), `loop`; idx=0; if clamped len=0 → stay IDLE, pulse `done_o` next cycle; else → LOAD. `start` outside IDLE ignored.
- LOAD (1 cycle): latch period/dur of entry idx, clear tick counter, `gen_reset_o`=1 → PLAY.
- PLAY: `gen_reset_o`=0, `maxval_o`=latched period, `tone_en_o`=(period≠0). Each `tick` increments tick counter (DW bits). Note ends on the cycle the dur-th tick is sampled; dur=0 ends the note on the first PLAY cycle.
- Note end: idx<len-1 → idx+1, LOAD. idx=len-1: `loop`=1 → idx=0, LOAD; else → IDLE, `done_o` pulse.
- `stop`=1 in any state → IDLE next cycle, no `done_o`. `stop` beats `start` and note end.
- IDLE outputs: `gen_reset_o`=1, `tone_en_o`=0, `busy_o`=0; `maxval_o` and `note_idx_o` hold last value.
- `tick` in IDLE or LOAD ignored.

## Timing
- All outputs registered. Reset values: `maxval_o`=0, `gen_reset_o`=1, `tone_en_o`=0, `busy_o`=0, `done_o`=0, `note_idx_o`=0, state IDLE, tick counter 0, table contents 0.
- `start` sampled at edge k → LOAD visible at k+1 (`busy_o`=1, `gen_reset_o`=1, `note_idx_o`=0), PLAY at k+2 with `maxval_o` valid and `tone_en_o` set.
- Note boundary: `gen_reset_o` high exactly one cycle; `tone_en_o` low that cycle.
- Note with dur=D, tick every cycle: PLAY lasts D cycles (1 cycle for D=0), plus 1 LOAD cycle.
- `done_o` asserted in the first IDLE cycle after the last note, together with `busy_o`=0.
- Reset mid-playback: all state and table return to reset values next edge.

## Test plan
- Reset: hold `reset` 2 cycles → `gen_reset_o`=1, all other outputs 0, `busy_o`=0.
- One-shot: entries {100,3},{200,2}, len=2, loop=0, tick every cycle, start → LOAD/PLAY×3 with `maxval_o`=100, LOAD/PLAY×2 with 200, `done_o` pulse, `gen_reset_o`=1 after.
- Rest and zero duration: entries {0,2},{50,0},{60,1}, len=3 → `tone_en_o`=0 for entry 0, entry 1 occupies 1 PLAY cycle, entry 2 sounds 1 tick.
- Loop and stop: len=2, loop=1 → idx sequence 0,1,0,1…; `stop` mid-PLAY → IDLE next cycle, `done_o` never pulses.
- Edge inputs: len=0 start → no LOAD, `done_o` one cycle; len=20 with AW=4 → plays 16 entries; start and stop same cycle → stays IDLE.
- Live write: rewrite entry 0 period 100→300 while entry 0 plays in loop → current note keeps 100, next pass shows 300.
